mux8_rr_sched: RTL and testbench
================================

// Module: mux8_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one 8:1 bit mux among NREQ requesters.
//   Arbitrates req[], issues a one-hot grant and drives the mux select with the
//   granted index. Holds the grant until the owner releases it.
//   Sits beside the mux: sel_o feeds the mux sel input, gnt_o goes back to the sources.
// PARAMETERS
//   NREQ      8   number of requesters; equals the mux input count
//   SEL_W     3   select width, clog2(NREQ)
//   MAX_HOLD  16  longest grant in cycles before forced release (timeout feature only)
// PORTS
//   clk        in   1      sole clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   req_i      in   NREQ   level request per source; bit k drives mux input k
//   mask_i     in   NREQ   1 = source k eligible; 0 = ignored by arbitration
//   done_i     in   1      release pulse from the current owner
//   gnt_o      out  NREQ   one-hot grant, registered
//   sel_o      out  SEL_W  mux select = index of the granted source, registered
//   busy_o     out  1      1 while any grant is held
//   timeout_o  out  1      1-cycle pulse on forced release
// BEHAVIOUR
//   Interface: one clock (clk); reset asynchronous, active-low (rst_n).
//   Reset values: gnt_o=0, sel_o=0, busy_o=0, timeout_o=0, state=IDLE,
//     ptr=NREQ-1 so the first search starts at index 0, hold_cnt=0.
//   Eligible vector: elig = req_i & mask_i.
//   Search: scan ptr+1, ptr+2, ... with wrap modulo NREQ. The first eligible index wins.
//   FSM IDLE:
//     - elig != 0 at edge N: at N+1, GRANT, gnt_o=onehot(w), sel_o=w, busy_o=1, ptr=w.
//     - elig == 0: stay IDLE, outputs unchanged. sel_o keeps its last value.
//   FSM GRANT:
//     - Release when done_i=1, req_i[ptr]=0, or mask_i[ptr]=0.
//     - On release with elig_next != 0: switch to the new winner at the same edge,
//       with no idle bubble. elig_next = elig, with bit ptr cleared if done_i=1 or
//       req_i[ptr]=0.
//     - If the owner alone stays eligible after a release on done_i, it is granted again.
//     - On release with no eligible source: go to IDLE, gnt_o=0, busy_o=0.
//       sel_o holds its value.
//   hold_cnt: cleared on every new grant, +1 per GRANT cycle, saturates at MAX_HOLD-1.
//   Latency: req rise to gnt_o is 1 cycle. sel_o always changes at the same edge as gnt_o.
//   Simultaneous events:
//     - done_i in IDLE is ignored.
//     - done_i and the owner's req drop in the same cycle count as one release.
//     - mask_i changes take effect at the next edge.
//   Invariants: gnt_o is 0 or one-hot. gnt_o[sel_o]=1 whenever busy_o=1.
//   rst_n low mid-grant: all outputs go to reset values immediately and the grant is lost.
// CONFIGURATION
//   MUX8_RR_SCHED_TIMEOUT_EN defined:
//     - GRANT with hold_cnt == MAX_HOLD-1 and no release: forced release at the next edge.
//     - timeout_o=1 for that one cycle.
//     - The timed-out owner's bit is excluded from that arbitration only.
//   Not defined: no forced release; timeout_o tied to 0; hold_cnt logic removed.
// TESTING
//   T1 reset: rst_n=0 asynchronously mid-grant -> gnt_o=0, sel_o=0, busy_o=0 at once,
//      without waiting for a clock edge.
//   T2 single: req_i=8'h08 after reset -> next cycle gnt_o=8'h08, sel_o=3.
//      Then done_i pulse -> gnt_o=0, busy_o=0.
//   T3 rotation: req_i=8'hFF held, done_i pulsed each grant -> sel_o sequence
//      0,1,...,7,0 with no idle cycle between grants.
//   T4 mask/drop: owner 2 with mask_i[2] cleared, req 5 pending -> next edge
//      gnt_o=8'h20, sel_o=5.
//   T5 re-grant: only req 6 active, done_i pulsed while req_i[6] stays 1 ->
//      gnt_o stays 8'h40 and hold_cnt restarts.
//   T6 timeout (macro defined, MAX_HOLD=16): req_i=8'h03, owner 0 never releases ->
//      16 cycles after the grant, timeout_o pulse and gnt_o=8'h02.
//      Without the macro, owner 0 holds indefinitely.

Source files
------------

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 bit mux among NREQ requesters.
// Optional forced release after MAX_HOLD cycles: define MUX8_RR_SCHED_TIMEOUT_EN.
module mux8_rr_sched #(
  parameter int NREQ     = 8,
  parameter int SEL_W    = $clog2(NREQ),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  mask_i,
  input  logic             done_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             timeout_o
);

  if (NREQ < 2 || SEL_W != $clog2(NREQ) || MAX_HOLD < 2) begin : g_param_err
    $error("mux8_rr_sched: invalid NREQ/SEL_W/MAX_HOLD combination");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_d, win_idx;
  logic [NREQ-1:0]  gnt_d, elig, cand;
  logic             timeout_d, owner_rel, force_rel, win_found, grant_now, at_limit;

  // Scans p+1, p+2, ... wrapping; p itself is visited last. The loop runs
  // backwards so the lowest offset from p is the last (winning) assignment.
  function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [SEL_W-1:0] p);
    logic [SEL_W:0] r;
    int             idx;
    r = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (v[idx]) r = {1'b1, SEL_W'(idx)};
    end
    return r;
  endfunction

`ifdef MUX8_RR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] hold_q, hold_d;

  assign at_limit = (hold_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (grant_now) hold_d = '0;
    else if (state_q == GRANT && !at_limit) hold_d = hold_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign at_limit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_o;
    gnt_d     = gnt_o;
    timeout_d = 1'b0;
    grant_now = 1'b0;

    elig      = req_i & mask_i;
    owner_rel = done_i | ~req_i[ptr_q] | ~mask_i[ptr_q];
    force_rel = (state_q == GRANT) & ~owner_rel & at_limit;

    // A releasing owner is scanned last, so it is re-granted only when it is
    // the sole eligible source; a timed-out owner sits out this round entirely.
    cand = elig;
    if (force_rel) cand[ptr_q] = 1'b0;
    {win_found, win_idx} = rr_pick(cand, ptr_q);

    case (state_q)
      IDLE: begin
        if (win_found) grant_now = 1'b1;
      end
      GRANT: begin
        if (owner_rel || force_rel) begin
          timeout_d = force_rel;
          if (win_found) begin
            grant_now = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_now) begin
      state_d = GRANT;
      ptr_d   = win_idx;
      sel_d   = win_idx;
      gnt_d   = NREQ'(1) << win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= SEL_W'(NREQ - 1);
      gnt_o     <= '0;
      sel_o     <= '0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_o     <= gnt_d;
      sel_o     <= sel_d;
      timeout_o <= timeout_d;
    end
  end

  assign busy_o = (state_q == GRANT);

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Self-checking bench for mux8_rr_sched: directed scenarios plus randomized
// traffic against a behavioural owner/pointer model.
module tb_mux8_rr_sched;
  localparam int NREQ     = 8;
  localparam int MAX_HOLD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NREQ-1:0] req_i = '0;
  logic [NREQ-1:0] mask_i = '0;
  logic            done_i = 1'b0;
  logic [NREQ-1:0] gnt_o;
  logic [2:0]      sel_o;
  logic            busy_o;
  logic            timeout_o;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the mux, where the search resumes, how long held.
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_hold;
  bit m_to;

  mux8_rr_sched #(.NREQ(NREQ), .SEL_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .mask_i   (mask_i),
    .done_i   (done_i),
    .gnt_o    (gnt_o),
    .sel_o    (sel_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_search(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = NREQ - 1;
    m_sel   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_ptr   = w;
    m_sel   = w;
    m_hold  = 0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] elig, nxt;
    int  w, o;
    bit  rel, forced;
    elig = req_i & mask_i;
    m_to = 1'b0;
    if (m_owner < 0) begin
      w = rr_search(elig, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      o      = m_owner;
      rel    = done_i || !req_i[o] || !mask_i[o];
      forced = 1'b0;
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
      if (!rel && m_hold == MAX_HOLD - 1) forced = 1'b1;
`endif
      if (rel || forced) begin
        nxt = elig;
        if (done_i || !req_i[o] || forced) nxt[o] = 1'b0;
        w = rr_search(nxt, m_ptr);
        if (w < 0 && done_i && !forced && elig[o]) w = o;
        m_to = forced;
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    check("gnt", 32'(gnt_o), 32'(exp_gnt));
    check("sel", 32'(sel_o), 32'(m_sel));
    check("busy", 32'(busy_o), 32'(m_owner >= 0));
    check("timeout", 32'(timeout_o), 32'(m_to));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    req_i  = '0;
    mask_i = '1;
    done_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_gnt", 32'(gnt_o), 32'h0);
    check("rst_sel", 32'(sel_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Drop rst_n between edges while a grant is held; outputs must clear at once.
  task automatic async_reset_mid_grant();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t1_gnt", 32'(gnt_o), 32'h0);
    check("t1_sel", 32'(sel_o), 32'h0);
    check("t1_busy", 32'(busy_o), 32'h0);
    check("t1_timeout", 32'(timeout_o), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Single requester, then release together with the request drop.
    req_i = 8'h08;
    step();
    check("t2_gnt", 32'(gnt_o), 32'h08);
    check("t2_sel", 32'(sel_o), 32'd3);
    req_i  = 8'h00;
    done_i = 1'b1;
    step();
    check("t2_rel_gnt", 32'(gnt_o), 32'h0);
    check("t2_rel_busy", 32'(busy_o), 32'h0);
    check("t2_rel_sel", 32'(sel_o), 32'd3);
    done_i = 1'b0;

    // Full rotation from reset with done held high: 0..7,0 back to back.
    apply_reset();
    req_i  = 8'hFF;
    done_i = 1'b1;
    for (int i = 0; i <= NREQ; i++) begin
      step();
      check("t3_sel", 32'(sel_o), 32'(i % NREQ));
      check("t3_busy", 32'(busy_o), 32'h1);
    end
    done_i = 1'b0;

    // Owner masked off while another request is pending.
    apply_reset();
    req_i = 8'h24;
    step();
    check("t4_first", 32'(gnt_o), 32'h04);
    mask_i = 8'hFB;
    step();
    check("t4_gnt", 32'(gnt_o), 32'h20);
    check("t4_sel", 32'(sel_o), 32'd5);
    async_reset_mid_grant();

    // Sole requester released on done stays granted.
    apply_reset();
    req_i = 8'h40;
    repeat (6) step();
    done_i = 1'b1;
    step();
    check("t5_gnt", 32'(gnt_o), 32'h40);
    done_i = 1'b0;
    repeat (20) step();

    // Owner never releases.
    apply_reset();
    req_i = 8'h03;
    step();
    check("t6_first", 32'(gnt_o), 32'h01);
    for (int k = 1; k <= 20; k++) begin
      step();
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
      if (k == MAX_HOLD) begin
        check("t6_pulse", 32'(timeout_o), 32'h1);
        check("t6_gnt", 32'(gnt_o), 32'h02);
      end
`else
      check("t6_hold", 32'(gnt_o), 32'h01);
`endif
    end

    // Randomized traffic: busy release phase, then long-hold phase.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n < 1500 || $urandom_range(0, 19) == 0) begin
        req_i  = ($urandom_range(0, 3) == 0) ? 8'hFF : NREQ'($urandom);
        mask_i = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : 8'hFF;
      end
      done_i = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      step();
      if (n == 2200) async_reset_mid_grant();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
